// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero entry 0, pending-result tracking,
// write-to-read bypass and a sequential clear engine that zeroes storage after reset.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic                     Reserve,
    input  logic [ADDR_W-1:0]        ResAddr,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdPending,
    input  logic [ADDR_W-1:0]        DbgAddr,
    output logic [DATA_W-1:0]        DbgData,
    output logic                     Ready
);

    // state | meaning
    // IDLE  | normal operation, reads/writes/reservations active
    // CLEAR | zeroing one entry per cycle from clr_cnt, all other traffic ignored
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DEPTH-1:0]    pending;
    logic [DEPTH-1:0]    pending_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   dbg_q;
    logic                ready_q;
    logic                wr_ok;
    logic                res_ok;

    assign wr_ok  = (state == IDLE) && WrEn && (WrAddr != '0);
    assign res_ok = (state == IDLE) && Reserve && (ResAddr != '0);

    // Reserve is applied last so it wins over a same-cycle write to the same entry
    always_comb begin
        pending_nxt = pending;
        if (wr_ok)
            pending_nxt[WrAddr] = 1'b0;
        if (res_ok)
            pending_nxt[ResAddr] = 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            pending <= '0;
            dbg_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            dbg_q   <= (DbgAddr == '0) ? '0 : mem[DbgAddr];
            pending <= pending_nxt;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (Clear) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; the clear engine owns zeroing it
    always_ff @(posedge Clock) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr_ok)
            mem[WrAddr] <= WrData;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = RdAddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            if ((BYPASS != 0) && wr_ok && (WrAddr == ra))
                rd = WrData;
            if ((state == CLEAR) || (ra == '0))
                rd = '0;
        end

        assign RdData[i*DATA_W +: DATA_W] = rd;
        assign RdPending[i]               = (state == IDLE) && pending[ra];
    end

    assign DbgData = dbg_q;
    assign Ready   = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp; a bypassing and a non-bypassing
// instance share stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

    logic        Clock;
    logic        Reset;
    logic        Clear;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        Reserve;
    logic [4:0]  ResAddr;
    logic [9:0]  RdAddr;
    logic [63:0] RdData, RdData_nb;
    logic [1:0]  RdPending, RdPending_nb;
    logic [4:0]  DbgAddr;
    logic [31:0] DbgData, DbgData_nb;
    logic        Ready, Ready_nb;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut (
        .Clock(Clock), .Reset(Reset), .Clear(Clear), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .Reserve(Reserve), .ResAddr(ResAddr), .RdAddr(RdAddr),
        .RdData(RdData), .RdPending(RdPending), .DbgAddr(DbgAddr), .DbgData(DbgData),
        .Ready(Ready)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_nb (
        .Clock(Clock), .Reset(Reset), .Clear(Clear), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .Reserve(Reserve), .ResAddr(ResAddr), .RdAddr(RdAddr),
        .RdData(RdData_nb), .RdPending(RdPending_nb), .DbgAddr(DbgAddr), .DbgData(DbgData_nb),
        .Ready(Ready_nb)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // reference model
    logic [31:0] mem_m [32];
    bit          pend_m [32];
    bit          clearing;
    int          clr_idx;
    bit          init_done;
    logic [31:0] dbg_m;
    bit          dbg_ok;

    int n_checks = 0;
    int n_fail   = 0;
    bit rdy_seen;
    int lows;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (clearing || a == 5'd0)
            return 32'd0;
        if (byp && WrEn && WrAddr == a)
            return WrData;
        return mem_m[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a);
        return !clearing && pend_m[a];
    endfunction

    task automatic model_edge();
        dbg_m  = (DbgAddr == 5'd0) ? 32'd0 : mem_m[DbgAddr];
        dbg_ok = init_done;
        if (clearing) begin
            mem_m[clr_idx] = 32'd0;
            clr_idx++;
            if (clr_idx == 32) begin
                clearing  = 1'b0;
                init_done = 1'b1;
            end
        end else begin
            if (WrEn && WrAddr != 5'd0) begin
                mem_m[WrAddr]  = WrData;
                pend_m[WrAddr] = 1'b0;
            end
            if (Reserve && ResAddr != 5'd0)
                pend_m[ResAddr] = 1'b1;
            if (Clear) begin
                clearing = 1'b1;
                clr_idx  = 0;
            end
        end
    endtask

    // entered just after a falling edge; checks, takes one rising edge, returns after next falling edge
    task automatic step();
        logic [4:0] a;
        #1;
        rdy_seen = Ready;
        check("ready", 32'(Ready), 32'(!clearing));
        check("ready_nb", 32'(Ready_nb), 32'(!clearing));
        for (int i = 0; i < 2; i++) begin
            a = RdAddr[i*5 +: 5];
            check($sformatf("rd%0d_a%0d", i, a), RdData[i*32 +: 32], exp_rd(1'b1, a));
            check($sformatf("rd%0d_nb_a%0d", i, a), RdData_nb[i*32 +: 32], exp_rd(1'b0, a));
            check($sformatf("pend%0d_a%0d", i, a), 32'(RdPending[i]), 32'(exp_pend(a)));
            check($sformatf("pend%0d_nb_a%0d", i, a), 32'(RdPending_nb[i]), 32'(exp_pend(a)));
        end
        if (dbg_ok) begin
            check("dbg", DbgData, dbg_m);
            check("dbg_nb", DbgData_nb, dbg_m);
        end
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    task automatic quiet();
        WrEn    = 1'b0;
        Reserve = 1'b0;
        Clear   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_dbg", DbgData, 32'd0);
        check("rst_rd", RdData[31:0], 32'd0);
        clearing = 1'b1;
        clr_idx  = 0;
        dbg_m    = 32'd0;
        dbg_ok   = 1'b1;
        for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    // counts cycles with Ready low; noisy drives random traffic only while the model is clearing
    task automatic run_until_ready(input bit noisy, output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (noisy && clearing) begin
                WrEn    = 1'($urandom_range(0, 1));
                WrAddr  = 5'($urandom_range(0, 31));
                WrData  = $urandom;
                Reserve = 1'($urandom_range(0, 1));
                ResAddr = 5'($urandom_range(0, 31));
                Clear   = ($urandom_range(0, 3) == 0);
                RdAddr  = 10'($urandom);
            end else begin
                quiet();
            end
            step();
            if (rdy_seen) break;
            n++;
        end
        quiet();
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        step();
        WrEn = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 32; r += 2) begin
            RdAddr = {5'(r + 1), 5'(r)};
            #1;
            check($sformatf("%s_r%0d", tag, r), RdData[31:0], 32'd0);
            check($sformatf("%s_r%0d", tag, r + 1), RdData[63:32], 32'd0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Clear = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
        Reserve = 1'b0; ResAddr = '0; RdAddr = '0; DbgAddr = '0;
        clearing = 1'b0; clr_idx = 0; init_done = 1'b0; dbg_ok = 1'b0; dbg_m = '0;
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = '0;
            pend_m[i] = 1'b0;
        end
        @(negedge Clock);

        // reset and initial clear
        do_reset();
        run_until_ready(1'b0, lows);
        check("reset_clear_len", 32'(lows), 32'd32);
        check_all_zero("after_reset");

        // write/read, shared read address, r0 hardwired
        write(5'd5, 32'hDEADBEEF);
        RdAddr = {5'd5, 5'd5};
        #1;
        check("r5_p0", RdData[31:0], 32'hDEADBEEF);
        check("r5_p1", RdData[63:32], 32'hDEADBEEF);
        step();
        write(5'd0, 32'h00001234);
        RdAddr = {5'd0, 5'd0};
        #1;
        check("r0_p0", RdData[31:0], 32'd0);
        check("r0_p1_nb", RdData_nb[63:32], 32'd0);
        step();

        // bypass vs no bypass
        write(5'd7, 32'h11111111);
        WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'hA5A5A5A5; RdAddr = {5'd0, 5'd7};
        #1;
        check("byp_r7", RdData[31:0], 32'hA5A5A5A5);
        check("nobyp_r7", RdData_nb[31:0], 32'h11111111);
        step();
        WrEn = 1'b0;

        // pending bits
        Reserve = 1'b1; ResAddr = 5'd3; RdAddr = {5'd0, 5'd3};
        step();
        Reserve = 1'b0;
        #1;
        check("pend_r3_set", 32'(RdPending[0]), 32'd1);
        step();
        write(5'd3, 32'h33333333);
        #1;
        check("pend_r3_clr", 32'(RdPending[0]), 32'd0);
        step();
        Reserve = 1'b1; ResAddr = 5'd3;
        write(5'd3, 32'h44444444);
        Reserve = 1'b0;
        #1;
        check("pend_r3_resv_wins", 32'(RdPending[0]), 32'd1);
        check("r3_data_written", RdData_nb[31:0], 32'h44444444);
        step();
        write(5'd3, 32'h55555555);

        // debug port latency
        write(5'd9, 32'h00000009);
        DbgAddr = 5'd9;
        #1;
        check("dbg_before", DbgData, 32'd0);
        step();
        #1;
        check("dbg_r9", DbgData, 32'h00000009);
        step();

        // clear sequence with traffic and re-pulses ignored
        for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
        RdAddr = {5'd31, 5'd17};
        #1;
        check("fill_r17", RdData[31:0], 32'd17);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        run_until_ready(1'b1, lows);
        check("clear_len", 32'(lows), 32'd32);
        check_all_zero("after_clear");

        // reset in the middle of a clear restarts it
        for (int i = 1; i < 32; i++) write(5'(i), 32'(i * 3));
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        repeat (10) step();
        do_reset();
        run_until_ready(1'b0, lows);
        check("restart_clear_len", 32'(lows), 32'd32);
        check_all_zero("after_restart");

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            WrEn    = 1'($urandom_range(0, 1));
            WrAddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            WrData  = $urandom;
            Reserve = ($urandom_range(0, 2) == 0);
            ResAddr = ($urandom_range(0, 3) == 0) ? WrAddr : 5'($urandom_range(0, 31));
            for (int i = 0; i < 2; i++)
                RdAddr[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? WrAddr : 5'($urandom_range(0, 31));
            DbgAddr = 5'($urandom_range(0, 31));
            step();
        end
        quiet();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
